// File: rtl/cache_pkg.sv
// Shared types and default geometry for the L1 cache controller and its storage array.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cache_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_IDX_W  = 3;
    localparam int DEF_TAG_W  = DEF_ADDR_W - DEF_IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE,
        RESPOND
    } state_t;

endpackage

// File: rtl/cache_l1_array.sv
// Direct-mapped line storage: tag/valid/dirty/data, one word per line.
// Latency: combinational read, write takes effect on the next clock edge.
// Backpressure: none, and every enabled write is accepted.
module cache_l1_array
    import cache_pkg::*;
#(
    parameter int IDX_W  = DEF_IDX_W,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IDX_W-1:0]  i_idx,
    output logic [TAG_W-1:0]  o_tag,
    output logic              o_valid,
    output logic              o_dirty,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_tag_en,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic              i_valid_en,
    input  logic              i_valid,
    input  logic              i_dirty_en,
    input  logic              i_dirty,
    input  logic              i_data_en,
    input  logic [DATA_W-1:0] i_data
);

    localparam int LINES = 1 << IDX_W;

    logic [LINES-1:0]  r_valid;
    logic [LINES-1:0]  r_dirty;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES];

    assign o_tag   = r_tag[i_idx];
    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];
    assign o_data  = r_data[i_idx];

    // State bits: cleared by reset so every line starts invalid and clean.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (i_valid_en) r_valid[i_idx] <= i_valid;
            if (i_dirty_en) r_dirty[i_idx] <= i_dirty;
        end
    end

    // Tag and data payload: never reset, because a line is only trusted when its valid bit is set.
    always_ff @(posedge clock) begin
        if (i_tag_en)  r_tag[i_idx]  <= i_tag;
        if (i_data_en) r_data[i_idx] <= i_data;
    end

endmodule

// File: rtl/cache_l1_ctrl.sv
// Direct-mapped write-back/write-allocate L1 controller with single-word L2 handshakes.
// Latency: hit or clean write miss = ready 2 cycles after accept; misses add L2 read and/or write time.
// Backpressure: requests are only sampled in IDLE; L2 strobes are held until l2_ready.
module cache_l1_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = DEF_IDX_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] read_data,
    output logic              ready,
    output logic              hit_L1,
    output logic [ADDR_W-1:0] l2_address,
    output logic [DATA_W-1:0] l2_write_data,
    output logic              l2_read,
    output logic              l2_write,
    input  logic [DATA_W-1:0] l2_read_data,
    input  logic              l2_ready
);

    localparam int TAG_W = ADDR_W - IDX_W;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_write;
    logic [DATA_W-1:0] r_read_data;
    logic              r_hit;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [TAG_W-1:0]  w_rd_tag;
    logic              w_rd_valid;
    logic              w_rd_dirty;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_hit;

    logic              w_tag_en;
    logic              w_valid_en;
    logic              w_valid;
    logic              w_dirty_en;
    logic              w_dirty;
    logic              w_data_en;
    logic [DATA_W-1:0] w_wr_data;

    assign w_idx     = r_addr[IDX_W-1:0];
    assign w_tag     = r_addr[ADDR_W-1:IDX_W];
    assign w_hit     = w_rd_valid && (w_rd_tag == w_tag);
    assign read_data = r_read_data;
    assign hit_L1    = r_hit;

    cache_l1_array #(
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clock      (clock),
        .reset      (reset),
        .i_idx      (w_idx),
        .o_tag      (w_rd_tag),
        .o_valid    (w_rd_valid),
        .o_dirty    (w_rd_dirty),
        .o_data     (w_rd_data),
        .i_tag_en   (w_tag_en),
        .i_tag      (w_tag),
        .i_valid_en (w_valid_en),
        .i_valid    (w_valid),
        .i_dirty_en (w_dirty_en),
        .i_dirty    (w_dirty),
        .i_data_en  (w_data_en),
        .i_data     (w_wr_data)
    );

    // State register; reset returns to IDLE at once, which drops the L2 strobes asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state, array write enables and L2/ready outputs, all decoded from the current state.
    always_comb begin
        w_next        = r_state;
        w_tag_en      = 1'b0;
        w_valid_en    = 1'b0;
        w_valid       = 1'b0;
        w_dirty_en    = 1'b0;
        w_dirty       = 1'b0;
        w_data_en     = 1'b0;
        w_wr_data     = r_wdata;
        ready         = 1'b0;
        l2_read       = 1'b0;
        l2_write      = 1'b0;
        l2_address    = '0;
        l2_write_data = '0;
        case (r_state)
            IDLE: begin
                if (read || write) w_next = COMPARE;
            end
            COMPARE: begin
                if (w_hit) begin
                    if (r_is_write) begin
                        w_data_en  = 1'b1;
                        w_dirty_en = 1'b1;
                        w_dirty    = 1'b1;
                    end
                    w_next = RESPOND;
                end else if (w_rd_valid && w_rd_dirty) begin
                    w_next = WRITEBACK;
                end else if (r_is_write) begin
                    // One-word lines: a write miss overwrites the whole line, no fetch needed.
                    w_tag_en   = 1'b1;
                    w_valid_en = 1'b1;
                    w_valid    = 1'b1;
                    w_dirty_en = 1'b1;
                    w_dirty    = 1'b1;
                    w_data_en  = 1'b1;
                    w_next     = RESPOND;
                end else begin
                    w_next = ALLOCATE;
                end
            end
            WRITEBACK: begin
                // Victim tag/data come straight from the array; nothing touches the line until l2_ready.
                l2_write      = 1'b1;
                l2_address    = {w_rd_tag, w_idx};
                l2_write_data = w_rd_data;
                if (l2_ready) begin
                    w_dirty_en = 1'b1;
                    if (r_is_write) begin
                        w_tag_en   = 1'b1;
                        w_valid_en = 1'b1;
                        w_valid    = 1'b1;
                        w_dirty    = 1'b1;
                        w_data_en  = 1'b1;
                        w_next     = RESPOND;
                    end else begin
                        w_dirty = 1'b0;
                        w_next  = ALLOCATE;
                    end
                end
            end
            ALLOCATE: begin
                l2_read    = 1'b1;
                l2_address = r_addr;
                if (l2_ready) begin
                    w_tag_en   = 1'b1;
                    w_valid_en = 1'b1;
                    w_valid    = 1'b1;
                    w_dirty_en = 1'b1;
                    w_dirty    = 1'b0;
                    w_data_en  = 1'b1;
                    w_wr_data  = l2_read_data;
                    w_next     = RESPOND;
                end
            end
            RESPOND: begin
                ready  = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request capture plus the held read_data/hit_L1 results.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_is_write  <= 1'b0;
            r_read_data <= '0;
            r_hit       <= 1'b0;
        end else begin
            if (r_state == IDLE && (read || write)) begin
                r_addr     <= address;
                r_wdata    <= write_data;
                r_is_write <= write;
            end
            if (r_state == COMPARE) begin
                r_hit <= w_hit;
                if (w_hit && !r_is_write) r_read_data <= w_rd_data;
            end
            if (r_state == ALLOCATE && l2_ready) r_read_data <= l2_read_data;
        end
    end

endmodule

// File: doc/cache_l1_ctrl.md
Name: cache_l1_ctrl

Overview:
- Direct-mapped, write-back, write-allocate L1 cache controller.
- Sits directly downstream of the board-level request source (address/write_data/read/write from switches) and directly upstream of the L2 level.
- Instantiated inside hierarquia_memoria.
- Produces read_data and hit_L1 for the display stage. Issues single-word L2 transactions on misses and dirty evictions.

Parameters:
ADDR_W, 16, address width (CPU and L2 side)
DATA_W, 16, data word width
IDX_W, 3, index bits; LINES = 2**IDX_W = 8 lines, one word per line

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
address  in  ADDR_W  request address; index = address[IDX_W-1:0], tag = address[ADDR_W-1:IDX_W]
write_data  in  DATA_W  store data
read  in  1  read request (level)
write  in  1  write request (level); wins if read also high
read_data  out  DATA_W  load result, held until next completed read
ready  out  1  one-cycle pulse: request complete
hit_L1  out  1  registered hit flag of last completed request
l2_address  out  ADDR_W  L2 word address
l2_write_data  out  DATA_W  eviction data
l2_read  out  1  L2 read strobe, held until l2_ready
l2_write  out  1  L2 write strobe, held until l2_ready
l2_read_data  in  DATA_W  L2 fill data, valid with l2_ready
l2_ready  in  1  L2 transaction complete (one-cycle pulse)

Behaviour:
- Reset (reset=0, async):
  - State IDLE; all valid/dirty bits 0.
  - read_data=0, ready=0, hit_L1=0, l2_read=0, l2_write=0, l2_address=0, l2_write_data=0.
  - Data/tag arrays need not clear.
  - Reset mid-transaction aborts immediately; L2 strobes drop asynchronously; the in-flight request is lost.
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE, RESPOND.
- IDLE: when read|write, register address, write_data and op (write if write=1) → COMPARE. Otherwise stay.
- COMPARE (one cycle): hit = valid[idx] & tag match. Latch hit_L1 <= hit.
  - Read hit: read_data <= data[idx] → RESPOND.
  - Write hit: data[idx] <= wdata, dirty[idx] <= 1 → RESPOND.
  - Miss with valid & dirty victim → WRITEBACK.
  - Miss with clean/invalid victim: read → ALLOCATE; write → write line (tag, valid=1, dirty=1, data) → RESPOND. No fetch is needed on a write miss because lines are one word.
- WRITEBACK:
  - l2_write=1, l2_address={victim_tag, idx}, l2_write_data=data[idx], held stable.
  - On l2_ready: dirty[idx] <= 0, drop l2_write.
  - Then: read → ALLOCATE; write → install the new line as in a clean write miss → RESPOND.
- ALLOCATE:
  - l2_read=1, l2_address=registered address.
  - On l2_ready: data[idx] <= l2_read_data, tag set, valid=1, dirty=0, read_data <= l2_read_data, drop l2_read → RESPOND.
- RESPOND: ready=1 for exactly one cycle → IDLE.
- l2_read and l2_write are never high together. Strobes are deasserted in the cycle after l2_ready is seen.
- Latency:
  - hit: ready 2 cycles after acceptance edge.
  - clean read miss: 2 + L2 latency + 1.
  - dirty miss adds one full L2 write.
- Inputs are ignored outside IDLE; a request held high is re-accepted on the IDLE cycle after RESPOND.
- hit_L1 and read_data hold between requests.
- A write leaves read_data unchanged.
- Index wrap: addresses differing only in tag alias to the same line (conflict eviction).

Decomposition:
- Shared package cache_pkg: state enum (IDLE, COMPARE, WRITEBACK, ALLOCATE, RESPOND), ADDR_W/DATA_W defaults, index/tag extraction widths.
- One sub-module cache_l1_array holds tag/valid/dirty/data storage.
  - Combinational read port.
  - Synchronous write port with per-field enables.
  - Async active-low clear of valid/dirty.
- cache_l1_ctrl holds the FSM and L2 handshake.

Test Plan:
- Reset then read 0x0005, L2 returns 0x00AB after 3 cycles: l2_read high with l2_address=0x0005; ready pulses once; read_data=0x00AB, hit_L1=0. Repeat read: ready at +2 cycles, hit_L1=1, no L2 activity.
- Write 0x0005 data 0x0123 (hit), then read 0x0005: hit_L1=1 both times, read_data=0x0123, no L2 strobes.
- Conflict: after the previous step, read 0x000D (same index 5): l2_write with l2_address=0x0005, l2_write_data=0x0123 completes before l2_read with l2_address=0x000D; hit_L1=0.
- Write miss to clean line 0x0002 data 0x7FFF: no L2 transaction; ready at +2; subsequent read 0x0002 hits with 0x7FFF.
- read=1 and write=1 together at 0x0003 data 0x0042: treated as write; read_data unchanged; later read returns 0x0042.
- Assert reset low while l2_read is high mid-ALLOCATE: l2_read drops immediately; after release, read of the same address misses (valid cleared), hit_L1=0, ready was never pulsed for the aborted request.
